// File: rtl/prg_pkg.sv
// Shared constants and types for the primary ray generator sequencer.
// Default raster size and in-flight ray budget live here.
package prg_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int NUM_RAYS = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DRAIN
    } seq_state_t;

    typedef logic [$clog2(SCREEN_W)-1:0] px_x_t;
    typedef logic [$clog2(SCREEN_H)-1:0] px_y_t;

    // Advance a one-hot phase word v0 -> v1 -> v2 -> v0.
    function automatic logic [2:0] ring_rotate(input logic [2:0] r);
        return {r[1:0], r[2]};
    endfunction

endpackage

// File: rtl/prg_pixel_sequencer_phase_ring.sv
// Free-running three-phase one-hot strobe generator.
// Bit 0 is v0, bit 1 is v1, bit 2 is v2.
module prg_phase_ring
    import prg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] ring
);

    // Rotate every cycle; reset parks the ring on v0.
    always_ff @(posedge clk) begin
        if (rst) ring <= 3'b001;
        else     ring <= ring_rotate(ring);
    end

endmodule

// File: rtl/prg_pixel_sequencer.sv
// Pixel sequencer: phase ring, raster scan, credit flow control.
// Optional stall counter output when PRG_SEQ_PERF_EN is defined.
module prg_pixel_sequencer #(
    parameter int SCREEN_W = prg_pkg::SCREEN_W,
    parameter int SCREEN_H = prg_pkg::SCREEN_H,
    parameter int CREDITS  = prg_pkg::NUM_RAYS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         ray_consumed,
    output logic                         v0,
    output logic                         v1,
    output logic                         v2,
    output logic [$clog2(SCREEN_W)-1:0]  x,
    output logic [$clog2(SCREEN_H)-1:0]  y,
    output logic                         x_y_valid,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(CREDITS+1)-1:0] credits_avail
`ifdef PRG_SEQ_PERF_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    import prg_pkg::*;

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
    localparam logic [CW-1:0] C_FULL = CW'(CREDITS);

    seq_state_t    state;
    seq_state_t    state_n;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic          slot_live;
    logic          slot_live_n;
    logic [CW-1:0] credits_n;
    logic          give;
    logic [2:0]    ring;

    prg_phase_ring u_ring (
        .clk  (clk),
        .rst  (rst),
        .ring (ring)
    );

    assign v0   = ring[0];
    assign v1   = ring[1];
    assign v2   = ring[2];
    assign busy = (state != IDLE);

    // A return only counts while some ray is actually outstanding.
    assign give = ray_consumed && (credits_avail != C_FULL);

    // Next state, raster advance, slot issue and credit update.
    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        slot_live_n = slot_live;
        x_y_valid   = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            IDLE: begin
                x_n         = '0;
                y_n         = '0;
                slot_live_n = 1'b0;
                if (start) state_n = ARMED;
            end
            ARMED: begin
                if (abort)   state_n = DRAIN;
                else if (v2) state_n = RUN;
            end
            RUN: begin
                if (v0 && credits_avail != '0) begin
                    x_y_valid   = 1'b1;
                    slot_live_n = 1'b1;
                end
                if (v2 && slot_live) begin
                    slot_live_n = 1'b0;
                    if (x == X_LAST) begin
                        x_n = '0;
                        if (y == Y_LAST) begin
                            y_n     = '0;
                            state_n = DRAIN;
                        end else begin
                            y_n = y + 1'b1;
                        end
                    end else begin
                        x_n = x + 1'b1;
                    end
                end
                if (abort) begin
                    state_n     = DRAIN;
                    x_n         = '0;
                    y_n         = '0;
                    slot_live_n = 1'b0;
                end
            end
            DRAIN: begin
                x_n         = '0;
                y_n         = '0;
                slot_live_n = 1'b0;
                if (credits_avail == C_FULL) begin
                    frame_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        credits_n = credits_avail;
        if (x_y_valid && !give)      credits_n = credits_avail - 1'b1;
        else if (give && !x_y_valid) credits_n = credits_avail + 1'b1;
    end

    // State, raster position and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            slot_live     <= 1'b0;
            credits_avail <= C_FULL;
        end else begin
            state         <= state_n;
            x             <= x_n;
            y             <= y_n;
            slot_live     <= slot_live_n;
            credits_avail <= credits_n;
        end
    end

`ifdef PRG_SEQ_PERF_EN
    // Count credit-starved issue slots; kept after the frame for readout.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == RUN && v0 && credits_avail == '0
                     && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A return with every credit home means downstream miscounted.
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ray_consumed && credits_avail == C_FULL));
`endif

endmodule

// File: tb/tb_prg_pixel_sequencer.sv
// Scoreboard bench for prg_pixel_sequencer on a 4x2 raster, 3 credits.
// Expected pixels are queued at start; a monitor checks every cycle.
module tb_prg_pixel_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int C  = 3;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int CW = $clog2(C + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ray_consumed = 1'b0;
    logic          v0, v1, v2;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_y_valid;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] credits_avail;
`ifdef PRG_SEQ_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state, owned by the monitor
    int  cyc = 0;
    bit  m_busy = 0;
    bit  aborted = 0;
    int  start_cyc = 0;
    int  last_issue = -10;
    int  issued_cnt = 0;
    int  shown = 0;
    int  outstanding = 0;
    longint m_stall = 0;
    int  exp_q[$];

    // stimulus knobs
    bit  consume_en = 0;
    int  cons_pct = 50;

    always #5 clk = ~clk;

    prg_pixel_sequencer #(
        .SCREEN_W (W),
        .SCREEN_H (H),
        .CREDITS  (C)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .ray_consumed  (ray_consumed),
        .v0            (v0),
        .v1            (v1),
        .v2            (v2),
        .x             (x),
        .y             (y),
        .x_y_valid     (x_y_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .credits_avail (credits_avail)
`ifdef PRG_SEQ_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    task automatic chk(input string n, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cyc %0d",
                     n, act, exp, cyc);
        end
    endtask

    // Monitor: evaluate the frame rules for this cycle and compare.
    always @(negedge clk) begin
        if (rst) begin
            cyc         = 0;
            m_busy      = 0;
            aborted     = 0;
            start_cyc   = 0;
            last_issue  = -10;
            issued_cnt  = 0;
            shown       = 0;
            outstanding = 0;
            m_stall     = 0;
            exp_q.delete();
        end else begin
            automatic int  ph = cyc % 3;
            automatic bit  slot_ok = m_busy && !aborted && ph == 0
                                     && cyc >= start_cyc + 2
                                     && issued_cnt < N;
            automatic bit  e_issue = slot_ok && outstanding < C;
            automatic bit  e_drain = m_busy && (aborted ||
                                     (issued_cnt == N &&
                                      cyc >= last_issue + 3));
            automatic bit  e_done = e_drain && outstanding == 0;
            automatic int  p = shown % N;
            automatic int  ex = (!m_busy || aborted) ? 0 : p % W;
            automatic int  ey = (!m_busy || aborted) ? 0 : p / W;
            automatic int  old = outstanding;

            chk("v0", v0, ph == 0);
            chk("v1", v1, ph == 1);
            chk("v2", v2, ph == 2);
            chk("x_y_valid", x_y_valid, e_issue);
            chk("busy", busy, m_busy);
            chk("frame_done", frame_done, e_done);
            chk("credits_avail", credits_avail, C - outstanding);
            chk("x", x, ex);
            chk("y", y, ey);
`ifdef PRG_SEQ_PERF_EN
            chk("stall_cycles", stall_cycles, m_stall);
`endif
            if (x_y_valid) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_queue_empty", 1, 0);
                end else begin
                    automatic int e = exp_q.pop_front();
                    chk("pix_x", x, e % 256);
                    chk("pix_y", y, e / 256);
                end
            end

            if (e_issue) begin
                outstanding++;
                issued_cnt++;
                last_issue = cyc;
            end
            if (ray_consumed && old > 0) outstanding--;
            if (slot_ok && old == C && m_stall != 64'hFFFF_FFFF)
                m_stall++;
            if (m_busy && !aborted && cyc == last_issue + 2)
                shown++;

            if (!m_busy) begin
                if (start) begin
                    m_busy     = 1;
                    aborted    = 0;
                    start_cyc  = cyc;
                    issued_cnt = 0;
                    shown      = 0;
                    m_stall    = 0;
                    exp_q.delete();
                    for (int r = 0; r < H; r++)
                        for (int c = 0; c < W; c++)
                            exp_q.push_back(r * 256 + c);
                end
            end else if (e_done) begin
                m_busy = 0;
            end else if (abort) begin
                aborted = 1;
                exp_q.delete();
            end
            cyc++;
        end
    end

    // One cycle of stimulus, driven just after the rising edge.
    task automatic step(input bit s, input bit a);
        start = s;
        abort = a;
        ray_consumed = consume_en && outstanding > 0
                       && ($urandom_range(99) < cons_pct);
        @(posedge clk);
        #1;
        start = 0;
        abort = 0;
        ray_consumed = 0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 3 && (cyc % 3) != p; i++) step(0, 0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            step(0, 0);
            n++;
        end
        if (m_busy) chk("wait_idle_timeout", n, -1);
    endtask

    task automatic wait_issued(input int k, input int budget);
        int n;
        n = 0;
        while (issued_cnt < k && n < budget) begin
            step(0, 0);
            n++;
        end
        if (issued_cnt < k) chk("wait_issue_timeout", issued_cnt, k);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 0;
        repeat (6) step(0, 0);

        // start and abort together in IDLE, start lands on v1
        consume_en = 1;
        cons_pct   = 40;
        wait_phase(1);
        step(1, 1);
        wait_idle(400);

        // start on a v0 cycle, prompt returns
        cons_pct = 100;
        wait_phase(0);
        step(1, 0);
        wait_idle(400);

        // credit stall: no returns, then a single return
        consume_en = 0;
        wait_phase(2);
        step(1, 0);
        repeat (24) step(0, 0);
        consume_en = 1;
        cons_pct   = 100;
        step(0, 0);
        consume_en = 0;
        repeat (12) step(0, 0);
        consume_en = 1;
        wait_idle(400);

        // abort with three rays in flight, then restart
        consume_en = 0;
        step(1, 0);
        wait_issued(3, 100);
        step(0, 1);
        repeat (10) step(0, 0);
        consume_en = 1;
        cons_pct   = 30;
        wait_idle(400);
        step(1, 0);
        wait_idle(400);

        // random traffic
        consume_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) cons_pct = $urandom_range(100, 5);
            step($urandom_range(15) == 0, $urandom_range(40) == 0);
        end
        consume_en = 1;
        cons_pct   = 100;
        wait_idle(400);

        // reset in the middle of a frame
        step(1, 0);
        repeat (10) step(0, 0);
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        repeat (6) step(0, 0);
        step(1, 0);
        wait_idle(400);
        repeat (3) step(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prg_pixel_sequencer.md
Name: prg_pixel_sequencer

Overview:
- Drives the primary ray generator. It produces the free-running three-phase strobe (v0/v1/v2), scans pixel coordinates in raster order, and issues one pixel per three-cycle slot with a valid flag.
- Downstream backpressure uses credits: one credit per slot in the ray FIFO that follows the generator.
- Sits between the frame controller (start/abort/frame_done) and the generator/FIFO pair.

Parameters:
- SCREEN_W, 640, pixels per row.
- SCREEN_H, 480, rows per frame.
- CREDITS, 16, downstream ray-FIFO entries; maximum rays in flight.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begin a frame
- abort  in  1  single-cycle pulse; terminate the frame
- ray_consumed  in  1  downstream popped one ray; returns one credit
- v0, v1, v2  out  1 each  one-hot phase strobes
- x  out  $clog2(SCREEN_W)  pixel column
- y  out  $clog2(SCREEN_H)  pixel row
- x_y_valid  out  1  pixel issued in this slot
- busy  out  1  state is not IDLE
- frame_done  out  1  single-cycle pulse at end of frame
- credits_avail  out  $clog2(CREDITS+1)  current credit count

Behaviour:
- Reset values: v0=1, v1=0, v2=0, x=0, y=0, x_y_valid=0, busy=0, frame_done=0, credits_avail=CREDITS, state=IDLE.
- Phase ring:
  - Rotates v0->v1->v2->v0 every cycle, in every state, unaffected by start or abort.
  - Exactly one strobe is high at any time.
  - The first cycle after reset deasserts has v0=1.
- States: IDLE, ARMED, RUN, DRAIN.
- IDLE:
  - start -> ARMED.
  - x and y are forced to 0.
- ARMED:
  - Waits for the next v0 cycle, then enters RUN, so the first slot is aligned.
  - If start arrives while v0=1, the next v0 is 3 cycles later.
- RUN, slot issue:
  - On a v0 cycle, if credits_avail>0, issue the slot: x_y_valid=1 for that v0 cycle only.
  - x and y are registered and held stable for the whole slot (v0..v2).
  - After v2 of an issued slot, advance x. At x=SCREEN_W-1, x wraps to 0 and y increments.
- RUN, stall: on a v0 cycle with credits_avail=0, the slot is skipped. x_y_valid=0 and x/y are held; retry at the next v0.
- RUN, last pixel: issuing x=SCREEN_W-1, y=SCREEN_H-1 moves to DRAIN after that slot's v2. x and y wrap to 0.
- DRAIN:
  - No issue.
  - When credits_avail==CREDITS: frame_done=1 for one cycle, then -> IDLE.
- Credits:
  - Decrement on issue, increment on ray_consumed.
  - Simultaneous issue and ray_consumed leaves the count unchanged.
  - ray_consumed while credits_avail==CREDITS is ignored (saturate); a sim assertion fires.
  - Credits track only the rays issued by this block.
- abort (any non-IDLE state):
  - Next cycle: state=DRAIN, x=y=0, no further issue.
  - frame_done fires when credits return, so downstream is flushed first.
  - abort in IDLE is ignored.
- start outside IDLE is ignored.
- Simultaneous start and abort in IDLE: start wins; abort applies only from ARMED onward.
- Reset mid-frame: all state returns to the reset values on the next edge. Credits are restored to CREDITS; the FIFO is reset by the same rst.

Optional Feature:
- Macro: PRG_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0], which counts v0 cycles in RUN where issue was blocked by zero credits.
  - The counter clears on start, saturates at all-ones, and is held through DRAIN/IDLE for readout.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package prg_pkg holds:
  - SCREEN_W, SCREEN_H and NUM_RAYS constants.
  - The seq_state_t enum {IDLE, ARMED, RUN, DRAIN}.
  - Typedefs px_x_t and px_y_t sized with $clog2.
- Sub-module prg_phase_ring (3-bit one-hot rotator, synchronous reset to 3'b001) generates v0/v1/v2. The top instantiates it and keeps the FSM, raster counters and credit counter.

Test Plan:
- Reset/phase, with default params: hold rst 4 cycles then release -> v0,v1,v2 = 1,0,0 / 0,1,0 / 0,0,1 repeating. busy=0, credits_avail=16.
- Small frame, no stall, with SCREEN_W=4, SCREEN_H=2, CREDITS=16, ray_consumed pulsed 5 cycles after each issue:
  - Pulse start -> 8 x_y_valid pulses, each 3 cycles apart on v0.
  - (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1).
  - frame_done fires once after the 8th credit returns; busy then drops.
- Credit stall, with CREDITS=2 and ray_consumed withheld:
  - Two issues, then credits_avail=0 and no x_y_valid; x=2, y=0 held across 4 slots.
  - One ray_consumed -> exactly one issue of (2,0) at the next v0.
- Simultaneous issue and ray_consumed on the same v0 with credits_avail=1 -> credits_avail stays 1 next cycle.
- Abort, SCREEN_W=4, SCREEN_H=2: abort after the 3rd issue with 3 credits outstanding:
  - No further x_y_valid; x=y=0.
  - frame_done only after the 3rd ray_consumed.
  - A following start re-issues from (0,0).
- Start alignment, default params: pulse start on a v1 cycle -> first x_y_valid on the following v0 (2 cycles later). Pulse start on a v0 cycle -> first issue 3 cycles later.
